mtl_frame_monitor: RTL

Receive-side companion to the MTL LCD display controller. Consumes the HD/VD sync and 24-bit RGB stream on the LCD clock. Recovers the pixel coordinates and checks the line and frame timing. Produces a per-frame signature of the 800×480 active area plus a probe-pixel capture. Sits on the LCD output bus (tap, no back-pressure) and is used for on-chip self-test and by the verification bench as the golden checker.

---
 rtl/mtl_timing_pkg.sv | 24 ++
 rtl/mtl_frame_signature.sv | 77 +++++++
 rtl/mtl_frame_monitor.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mtl_timing_pkg.sv
// Shared MTL LCD timing constants, monitor state encoding and signature helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mtl_timing_pkg;

   // 800x480 panel timing: clocks per line, lines per frame, blanking and porches.
   localparam int H_LINE        = 1056;
   localparam int V_LINE        = 525;
   localparam int H_BLANK       = 46;
   localparam int H_FRONT_PORCH = 210;
   localparam int V_BLANK       = 23;
   localparam int V_FRONT_PORCH = 22;

   localparam int ACTIVE_W = H_LINE - H_FRONT_PORCH - H_BLANK;  // 800
   localparam int ACTIVE_H = V_LINE - V_FRONT_PORCH - V_BLANK;  // 480

   typedef enum logic [1:0] {SEARCH, LINE, HLOCK, LOCKED} mon_state_t;

   // One step of the frame signature rotation.
   function automatic logic [15:0] rotl1(input logic [15:0] v);
      return {v[14:0], v[15]};
   endfunction

endpackage

// File: rtl/mtl_frame_signature.sv
// Per-frame checksum accumulator, probe-pixel shadow and publish registers.
// Latency: accumulates in 1 clock; published values appear 2 clocks after publish.
// Backpressure: none; pure tap, every qualified pixel is consumed.
// Ports: clear (frame start, also samples probeX/probeY), en (accumulate pixel),
//        publish (last pixel of a locked frame), pix*/px/py pixel and coordinates,
//        frameDone pulse with checksum and probe colour outputs.
module mtl_frame_signature (
   input  logic        iCLK,
   input  logic        iRST_n,
   input  logic        clear,
   input  logic        en,
   input  logic        publish,
   input  logic [7:0]  pixR,
   input  logic [7:0]  pixG,
   input  logic [7:0]  pixB,
   input  logic [9:0]  px,
   input  logic [8:0]  py,
   input  logic [9:0]  probeX,
   input  logic [8:0]  probeY,
   output logic        frameDone,
   output logic [15:0] checksum,
   output logic [7:0]  probeR,
   output logic [7:0]  probeG,
   output logic [7:0]  probeB
);
   import mtl_timing_pkg::*;

   logic [15:0] acc;
   logic [7:0]  shR, shG, shB;
   logic [9:0]  probeXq;
   logic [8:0]  probeYq;
   logic        publishD;

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         acc       <= '0;
         shR       <= '0;
         shG       <= '0;
         shB       <= '0;
         probeXq   <= '0;
         probeYq   <= '0;
         publishD  <= 1'b0;
         frameDone <= 1'b0;
         checksum  <= '0;
         probeR    <= '0;
         probeG    <= '0;
         probeB    <= '0;
      end else begin
         // Shadow is cleared each frame so an unreachable probe publishes zero.
         if (clear) begin
            acc     <= '0;
            shR     <= '0;
            shG     <= '0;
            shB     <= '0;
            probeXq <= probeX;
            probeYq <= probeY;
         end else if (en) begin
            acc <= rotl1(acc) ^ {pixR, pixG} ^ {8'h00, pixB};
            if (px == probeXq && py == probeYq) begin
               shR <= pixR;
               shG <= pixG;
               shB <= pixB;
            end
         end
         // Publish one cycle after the last pixel so acc already includes it.
         publishD  <= publish;
         frameDone <= publishD;
         if (publishD) begin
            checksum <= acc;
            probeR   <= shR;
            probeG   <= shG;
            probeB   <= shB;
         end
      end
   end

endmodule

// File: rtl/mtl_frame_monitor.sv
// LCD receive-side monitor: recovers coordinates, checks HD/VD timing, signs each frame.
// Latency: oX/oY/oActive 2 clocks, oLocked/oErrCnt 2 clocks, frame results 3 clocks.
// Backpressure: none; passive tap on the LCD bus.
// Ports: iCLK/iRST_n clock and async active-low reset; iHD/iVD active-low syncs;
//        iLCD_R/G/B pixel; iProbeX/iProbeY probe coordinate; oLocked, oX, oY, oActive,
//        oFrameDone, oChecksum, oProbeR/G/B, oErrCnt status and results.
module mtl_frame_monitor #(
   parameter int H_LINE                 = mtl_timing_pkg::H_LINE,
   parameter int V_LINE                 = mtl_timing_pkg::V_LINE,
   parameter int Horizontal_Blank       = mtl_timing_pkg::H_BLANK,
   parameter int Horizontal_Front_Porch = mtl_timing_pkg::H_FRONT_PORCH,
   parameter int Vertical_Blank         = mtl_timing_pkg::V_BLANK,
   parameter int Vertical_Front_Porch   = mtl_timing_pkg::V_FRONT_PORCH
) (
   input  logic        iCLK,
   input  logic        iRST_n,
   input  logic        iHD,
   input  logic        iVD,
   input  logic [7:0]  iLCD_R,
   input  logic [7:0]  iLCD_G,
   input  logic [7:0]  iLCD_B,
   input  logic [9:0]  iProbeX,
   input  logic [8:0]  iProbeY,
   output logic        oLocked,
   output logic [9:0]  oX,
   output logic [8:0]  oY,
   output logic        oActive,
   output logic        oFrameDone,
   output logic [15:0] oChecksum,
   output logic [7:0]  oProbeR,
   output logic [7:0]  oProbeG,
   output logic [7:0]  oProbeB,
   output logic [7:0]  oErrCnt
);
   import mtl_timing_pkg::*;

   localparam int H_END = H_LINE - Horizontal_Front_Porch - 1;
   localparam int V_END = V_LINE - Vertical_Front_Porch - 1;

   localparam logic [10:0] X_LAST  = 11'(H_LINE - 1);
   localparam logic [9:0]  Y_LAST  = 10'(V_LINE - 1);
   localparam logic [10:0] X_FIRST = 11'(Horizontal_Blank);
   localparam logic [10:0] X_END   = 11'(H_END);
   localparam logic [9:0]  Y_FIRST = 10'(Vertical_Blank);
   localparam logic [9:0]  Y_END   = 10'(V_END);
   localparam logic [9:0]  PX_LAST = 10'(H_END - Horizontal_Blank);
   localparam logic [8:0]  PY_LAST = 9'(V_END - Vertical_Blank);

   // Input stage. Syncs reset to idle-high so reset release cannot fake a line start.
   logic       rHd, rHdD, rVd;
   logic [7:0] rR, rG, rB;
   logic [9:0] rProbeX;
   logic [8:0] rProbeY;

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         rHd     <= 1'b1;
         rHdD    <= 1'b1;
         rVd     <= 1'b1;
         rR      <= '0;
         rG      <= '0;
         rB      <= '0;
         rProbeX <= '0;
         rProbeY <= '0;
      end else begin
         rHd     <= iHD;
         rHdD    <= rHd;
         rVd     <= iVD;
         rR      <= iLCD_R;
         rG      <= iLCD_G;
         rB      <= iLCD_B;
         rProbeX <= iProbeX;
         rProbeY <= iProbeY;
      end
   end

   logic ls, fs;
   assign ls = !rHd && rHdD;
   assign fs = ls && !rVd;

   // xCnt/yCnt hold the previous pixel's position; xNext/yNext are the position
   // of the pixel now in the input stage. Period checks use the former.
   logic [10:0] xCnt, xNext;
   logic [9:0]  yCnt, yNext;

   always_comb begin
      xNext = xCnt;
      if (ls)
         xNext = '0;
      else if (xCnt != '1)
         xNext = xCnt + 11'd1;
      yNext = yCnt;
      if (fs)
         yNext = '0;
      else if (ls && yCnt != '1)
         yNext = yCnt + 10'd1;
   end

   mon_state_t state, stateNext;
   logic       lineEnd, err;

   assign lineEnd = (xCnt == X_LAST);
   assign err = (state == LOCKED) &&
                ((ls && !lineEnd) || (!ls && lineEnd) ||
                 (fs && yCnt != Y_LAST) || (ls && !fs && yCnt == Y_LAST));

   always_comb begin
      stateNext = state;
      case (state)
         SEARCH: if (ls) stateNext = LINE;
         LINE:   if (ls && lineEnd) stateNext = HLOCK;
         HLOCK: begin
            if (ls) begin
               if (!lineEnd)
                  stateNext = LINE;
               else if (fs)
                  stateNext = LOCKED;
            end else if (lineEnd) begin
               stateNext = LINE;
            end
         end
         LOCKED: if (err) stateNext = SEARCH;
         default: stateNext = SEARCH;
      endcase
   end

   // Active-area coordinates, truncated to the output widths.
   logic       active, lastPix, en, publish;
   logic [9:0] px;
   logic [8:0] py;

   assign active  = (xNext >= X_FIRST) && (xNext <= X_END) &&
                    (yNext >= Y_FIRST) && (yNext <= Y_END);
   assign px      = xNext[9:0] - X_FIRST[9:0];
   assign py      = yNext[8:0] - Y_FIRST[8:0];
   assign lastPix = (px == PX_LAST) && (py == PY_LAST);
   // LOCKED is only entered at a frame start, so being LOCKED at the last
   // pixel means the whole frame was locked. An error in that cycle wins.
   assign en      = (state == LOCKED) && active;
   assign publish = en && lastPix && !err;

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state   <= SEARCH;
         xCnt    <= '0;
         yCnt    <= '0;
         oErrCnt <= '0;
         oX      <= '0;
         oY      <= '0;
         oActive <= 1'b0;
      end else begin
         state <= stateNext;
         xCnt  <= xNext;
         yCnt  <= yNext;
         if (err && oErrCnt != 8'hFF)
            oErrCnt <= oErrCnt + 8'd1;
         oActive <= active;
         if (active) begin
            oX <= px;
            oY <= py;
         end
      end
   end

   assign oLocked = (state == LOCKED);

   mtl_frame_signature uSig (
      .iCLK      (iCLK),
      .iRST_n    (iRST_n),
      .clear     (fs),
      .en        (en),
      .publish   (publish),
      .pixR      (rR),
      .pixG      (rG),
      .pixB      (rB),
      .px        (px),
      .py        (py),
      .probeX    (rProbeX),
      .probeY    (rProbeY),
      .frameDone (oFrameDone),
      .checksum  (oChecksum),
      .probeR    (oProbeR),
      .probeG    (oProbeG),
      .probeB    (oProbeB)
   );

endmodule
